// File: rtl/avl_read_responder.sv
// Avalon-MM read/write responder backed by a 2^ADDR_W x 32 word memory.
// Wait states and read latency are sequenced by an explicit FSM; all outputs are registered.
module avl_read_responder #(
    parameter int ADDR_W       = 8,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic              waitrequest,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    output logic [15:0]       rd_count
);

    localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int LC_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(WAIT_CYCLES);
    localparam logic [LC_W-1:0] LC_LOAD = LC_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STALL   = 3'd1,
        RACCEPT = 3'd2,
        LAT     = 3'd3,
        VALID   = 3'd4,
        WACCEPT = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [WC_W-1:0]   wcnt, wcnt_n;
    logic [LC_W-1:0]   lcnt, lcnt_n;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_be;
    logic [31:0]       mem [2**ADDR_W];

    logic              mem_we;
    logic              lat_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        rd_be;
    logic [31:0]       rd_word;
    logic              waitrequest_n;
    logic              readdatavalid_n;
    logic [31:0]       readdata_n;
    logic [15:0]       rd_count_n;

    // State register, counters, latched command and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wcnt          <= '0;
            lcnt          <= '0;
            lat_addr      <= '0;
            lat_be        <= '0;
            waitrequest   <= 1'b1;
            readdatavalid <= 1'b0;
            readdata      <= '0;
            rd_count      <= '0;
        end else begin
            state         <= state_n;
            wcnt          <= wcnt_n;
            lcnt          <= lcnt_n;
            waitrequest   <= waitrequest_n;
            readdatavalid <= readdatavalid_n;
            readdata      <= readdata_n;
            rd_count      <= rd_count_n;
            if (lat_en) begin
                lat_addr <= address;
                lat_be   <= byteenable;
            end
        end
    end

    // Next-state logic; a dropped request in any waiting state falls back to IDLE
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        lcnt_n  = lcnt;
        case (state)
            IDLE: begin
                if (read) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n = RACCEPT;
                    end else begin
                        state_n = STALL;
                        wcnt_n  = WC_LOAD;
                    end
                end else if (write) begin
                    state_n = WACCEPT;
                end
            end
            STALL: begin
                wcnt_n = wcnt - WC_W'(1);
                if (!read) begin
                    state_n = IDLE;
                end else if (wcnt <= WC_W'(1)) begin
                    state_n = RACCEPT;
                end
            end
            RACCEPT: begin
                if (!read) begin
                    state_n = IDLE;
                end else if (READ_LATENCY <= 1) begin
                    state_n = VALID;
                end else begin
                    state_n = LAT;
                    lcnt_n  = LC_LOAD;
                end
            end
            LAT: begin
                lcnt_n = lcnt - LC_W'(1);
                if (lcnt <= LC_W'(1)) begin
                    state_n = VALID;
                end
            end
            VALID:   state_n = IDLE;
            WACCEPT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        mem_we  = (state == WACCEPT) && write && !reset;
        lat_en  = (state == RACCEPT) && read;
        // With unit latency the data is fetched on the accepting edge itself
        rd_addr = (state == RACCEPT) ? address : lat_addr;
        rd_be   = (state == RACCEPT) ? byteenable : lat_be;
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = rd_be[i] ? mem[rd_addr][8*i +: 8] : 8'h00;
        end
        waitrequest_n   = !((state_n == RACCEPT) || (state_n == WACCEPT));
        readdatavalid_n = (state_n == VALID);
        readdata_n      = readdatavalid_n ? rd_word : readdata;
        rd_count_n      = (readdatavalid_n && (rd_count != 16'hFFFF)) ? rd_count + 16'd1 : rd_count;
    end

    // Sample memory is never cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[address][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/avl_read_responder.md
Name: avl_read_responder

Overview:
- Avalon-MM slave (responder) that serves reads issued by the flash/audio read masters.
- Lets the read FSM and sample path be exercised in simulation, and stands in for on-chip sample memory.
- Word memory of 2^ADDR_W x 32 bits; writes preload it, reads return data after programmable wait states and read latency.
- Waitrequest and readdatavalid are generated by an explicit state machine.

Parameters:
- ADDR_W, 8: word address width; memory depth is 2^ADDR_W.
- WAIT_CYCLES, 2: stall cycles, waitrequest held high before a command is accepted (0 allowed).
- READ_LATENCY, 2: cycles from read acceptance to readdatavalid (minimum 1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  word address from master.
- read  input  1  read request, held by master until accepted.
- write  input  1  write request, held by master until accepted.
- writedata  input  32  write data.
- byteenable  input  4  byte lane enables for read and write.
- waitrequest  output  1  high = command not accepted this cycle.
- readdata  output  32  read data, valid only with readdatavalid.
- readdatavalid  output  1  one-cycle pulse marking readdata valid.
- rd_count  output  16  number of completed reads, saturates at 16'hFFFF.

Behaviour:
- Reset values (reset sampled high at posedge): state=IDLE, waitrequest=1, readdatavalid=0, readdata=0, rd_count=0, internal counters=0. Memory contents are not cleared.
- Reset mid-transaction aborts it; no readdatavalid is ever produced for an aborted read.
- All outputs are registered.
- A command is accepted on the posedge where the master holds read or write high and waitrequest=0.
- States:
  - IDLE: waitrequest=1.
    - read=1: go to STALL with wcnt=WAIT_CYCLES, or directly to RACCEPT if WAIT_CYCLES=0.
    - else write=1: go to WACCEPT.
    - read and write both high: read wins, write stays pending and is served after the read completes.
  - STALL: waitrequest=1. Decrement wcnt; go to RACCEPT when wcnt reaches 1.
  - RACCEPT: waitrequest=0 for exactly one cycle.
    - At the closing edge: latch address and byteenable; load lcnt=READ_LATENCY-1; go to LAT, or to VALID if READ_LATENCY=1.
  - LAT: waitrequest=1. Decrement lcnt; go to VALID when lcnt reaches 1.
  - VALID: readdatavalid=1 for one cycle.
    - readdata = mem[latched addr] with disabled byte lanes forced to 8'h00.
    - rd_count increments (saturating).
    - Next state IDLE; readdatavalid returns to 0.
  - WACCEPT: waitrequest=0 for one cycle.
    - At the closing edge, write enabled byte lanes of writedata into mem[address]; other lanes unchanged.
    - Next state IDLE.
- Latency, first read sample in IDLE to readdatavalid: 1 + WAIT_CYCLES + READ_LATENCY cycles (defaults: 5).
- Write cost: 2 cycles (IDLE, WACCEPT).
- Only one outstanding read; no pipelining. waitrequest stays high until VALID completes.
- readdata holds its last value outside VALID; it is not cleared.
- Protocol violation (read or write dropped while in STALL/RACCEPT/WACCEPT): return to IDLE, no memory update, no readdatavalid.
- Address wrap: address is exactly ADDR_W bits, so there is no out-of-range case.
- Read-after-write to the same address returns the new data: the write commits before the read can be accepted.

Test Plan:
- Write then read, defaults: write 32'hDEADBEEF to addr 8'h10 with be=4'hF, then read addr 8'h10 be=4'hF.
  - waitrequest low for exactly 1 cycle in the write.
  - Read: waitrequest high 3 cycles then low 1, readdatavalid pulses 5 cycles after read first sampled.
  - readdata=32'hDEADBEEF, rd_count=1.
- Byte lanes: write 32'h11223344 be=4'h5 over existing 32'hAABBCCDD at addr 3, then read with be=4'hF and be=4'h3.
  - Results: 32'hAA22CC44 and 32'h0000CC44.
- Zero-wait / min latency (WAIT_CYCLES=0, READ_LATENCY=1): read addr 0 holding 32'h12345678.
  - waitrequest low in the 2nd cycle; readdatavalid in the 3rd cycle, data 32'h12345678.
- Simultaneous read and write in IDLE (read addr 5, write addr 5 data 32'hCAFEF00D, old value 32'h0):
  - Read completes first with 32'h0, then the write is accepted.
  - A following read of addr 5 returns 32'hCAFEF00D.
- Reset mid-read: assert reset during LAT.
  - No readdatavalid; waitrequest=1, rd_count=0 the cycle after reset.
  - A subsequent read still returns the preloaded memory value.
- Back-to-back reads of addr 1..4 driven by the read FSM master:
  - Four readdatavalid pulses, each 5 cycles after its request is sampled; rd_count=4.
